vga_frame_capture: RTL and testbench

VGA_FRAME_CAPTURE -- requirements
Module: vga_frame_capture

---
 rtl/vga_cap_pkg.sv | 26 ++
 rtl/vga_frame_capture_fifo.sv | 72 +++++++
 rtl/vga_frame_capture.sv | 166 ++++++++++++++++
 tb/tb_vga_frame_capture.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cap_pkg.sv
// Shared constants and types for the VGA frame capture block.
// Default timing is standard 640x480@60.
package vga_cap_pkg;

    localparam int VGA_HPERIOD = 800;
    localparam int VGA_VPERIOD = 525;
    localparam int VGA_HBLANK  = 160;
    localparam int VGA_VBLANK  = 45;

    localparam int FIFO_WIDTH  = 26;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } cap_state_t;

    // Layout of one buffered word: start-of-frame, end-of-line, RGB888
    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [23:0] data;
    } cap_word_t;

endpackage

// File: rtl/vga_frame_capture_fifo.sv
// Synchronous FIFO with a registered head word (cap_fifo).
// The head register counts as one of the DEPTH entries.
module cap_fifo
    import vga_cap_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;
    logic             pop;
    logic             push;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = rd_en && !empty;
    assign push  = wr_en && (!full || pop);

    // A word written into an otherwise empty FIFO bypasses memory into the head register
    always_comb begin
        rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next  = count + CW'(push) - CW'(pop);
        if (push && ((count - CW'(pop)) == '0)) begin
            head_next = wr_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            if (count_next != '0) begin
                rd_data <= head_next;
            end
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// Captures N frames of active video from a sync generator, expands colour to
// RGB888 and streams words through a ready/valid FIFO.
module vga_frame_capture
    import vga_cap_pkg::*;
#(
    parameter int HPERIOD    = VGA_HPERIOD,
    parameter int VPERIOD    = VGA_VPERIOD,
    parameter int HBLANK     = VGA_HBLANK,
    parameter int VBLANK     = VGA_VBLANK,
    parameter int CDEPTH     = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [9:0]        HCNT,
    input  logic [9:0]        VCNT,
    input  logic [CDEPTH-1:0] VGA_R,
    input  logic [CDEPTH-1:0] VGA_G,
    input  logic [CDEPTH-1:0] VGA_B,
    input  logic              START,
    input  logic [7:0]        NFRAMES,
    input  logic              REPL,
    output logic [23:0]       OUT_DATA,
    output logic              OUT_SOF,
    output logic              OUT_EOL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVF
);

    localparam logic [9:0] H_FIRST = 10'(HBLANK);
    localparam logic [9:0] H_LAST  = 10'(HPERIOD - 1);
    localparam logic [9:0] V_FIRST = 10'(VBLANK);
    localparam logic [9:0] V_LAST  = 10'(VPERIOD - 1);

    cap_state_t  state;
    cap_state_t  state_next;

    logic [9:0]        s1_hcnt;
    logic [9:0]        s1_vcnt;
    logic [CDEPTH-1:0] s1_r;
    logic [CDEPTH-1:0] s1_g;
    logic [CDEPTH-1:0] s1_b;

    logic [7:0] frames_left;
    logic       ovf_flag;

    logic raw_fstart;
    logic s1_active;
    logic s1_fstart;
    logic s1_fend;
    logic s1_eol;
    logic push_req;
    logic push_ok;
    logic pop;
    logic drain_done;

    cap_word_t                   push_word;
    cap_word_t                   fifo_word;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;

    // Repeat the channel MSB-first across 8 bits, or stop after one copy for zero-fill
    function automatic logic [7:0] expand(input logic [CDEPTH-1:0] c, input logic repl);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (repl || (i < CDEPTH)) begin
                r[7-i] = c[CDEPTH-1-(i % CDEPTH)];
            end
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_hcnt <= '0;
            s1_vcnt <= '0;
            s1_r    <= '0;
            s1_g    <= '0;
            s1_b    <= '0;
        end else begin
            s1_hcnt <= HCNT;
            s1_vcnt <= VCNT;
            s1_r    <= VGA_R;
            s1_g    <= VGA_G;
            s1_b    <= VGA_B;
        end
    end

    // Arming looks at the live counters so the frame-start pixel is already
    // in stage 1 on the first CAPTURE cycle; frame end is judged in stage 1.
    assign raw_fstart = (HCNT == H_FIRST) && (VCNT == V_FIRST);
    assign s1_active  = (s1_hcnt >= H_FIRST) && (s1_vcnt >= V_FIRST);
    assign s1_fstart  = (s1_hcnt == H_FIRST) && (s1_vcnt == V_FIRST);
    assign s1_fend    = (s1_hcnt == H_LAST) && (s1_vcnt == V_LAST);
    assign s1_eol     = (s1_hcnt == H_LAST);

    assign push_req       = (state == CAPTURE) && s1_active;
    assign pop            = OUT_VALID && OUT_READY;
    assign push_ok        = !fifo_full || pop;
    assign push_word.sof  = s1_fstart;
    assign push_word.eol  = s1_eol;
    assign push_word.data = {expand(s1_r, REPL), expand(s1_g, REPL), expand(s1_b, REPL)};

    assign drain_done = (state == DRAIN) && (fifo_count == '0) && !push_req;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = ARM;
            ARM:     if (raw_fstart) state_next = CAPTURE;
            CAPTURE: if (s1_fend && (frames_left == 8'd1)) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            frames_left <= '0;
            ovf_flag    <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && START) begin
                frames_left <= (NFRAMES == 8'd0) ? 8'd1 : NFRAMES;
                ovf_flag    <= 1'b0;
            end else begin
                if ((state == CAPTURE) && s1_fend && (frames_left != 8'd0)) begin
                    frames_left <= frames_left - 8'd1;
                end
                if (push_req && !push_ok) begin
                    ovf_flag <= 1'b1;
                end
            end
        end
    end

    cap_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (push_req),
        .wr_data (push_word),
        .rd_en   (OUT_READY),
        .rd_data (fifo_word),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign OUT_VALID = !fifo_empty;
    assign OUT_DATA  = fifo_word.data;
    assign OUT_SOF   = fifo_word.sof;
    assign OUT_EOL   = fifo_word.eol;
    assign BUSY      = (state != IDLE);
    assign DONE      = drain_done;
    assign OVF       = ovf_flag;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Self-checking bench for vga_frame_capture using a shrunken video timing and
// a frame-level scoreboard of expected output words.
module tb_vga_frame_capture;

    localparam int HP = 20;
    localparam int VP = 10;
    localparam int HB = 4;
    localparam int VB = 3;
    localparam int CD = 4;
    localparam int FD = 16;
    localparam int FRAME_LINES = VP - VB;
    localparam int FRAME_WORDS = (HP - HB) * FRAME_LINES;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [9:0]    HCNT = '0;
    logic [9:0]    VCNT = '0;
    logic [CD-1:0] VGA_R = '0;
    logic [CD-1:0] VGA_G = '0;
    logic [CD-1:0] VGA_B = '0;
    logic          START = 1'b0;
    logic [7:0]    NFRAMES = '0;
    logic          REPL = 1'b0;
    logic [23:0]   OUT_DATA;
    logic          OUT_SOF;
    logic          OUT_EOL;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic          OVF;

    vga_frame_capture #(
        .HPERIOD    (HP),
        .VPERIOD    (VP),
        .HBLANK     (HB),
        .VBLANK     (VB),
        .CDEPTH     (CD),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .HCNT      (HCNT),
        .VCNT      (VCNT),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .START     (START),
        .NFRAMES   (NFRAMES),
        .REPL      (REPL),
        .OUT_DATA  (OUT_DATA),
        .OUT_SOF   (OUT_SOF),
        .OUT_EOL   (OUT_EOL),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    // stimulus configuration
    int          hc = 0;
    int          vc = 0;
    int          ready_mode = 0;
    logic [7:0]  cfg_nframes = '0;
    logic        cfg_repl = 1'b0;
    logic        cfg_fixed = 1'b0;
    logic [3:0]  fix_r = '0;
    logic [3:0]  fix_g = '0;
    logic [3:0]  fix_b = '0;

    // frame-level model: 0 idle, 1 armed, 2 capturing, 3 finished
    int          m_mode = 0;
    int          m_frames_left = 0;
    logic [25:0] exp_q[$];
    int          push_idx = 0;
    int          sof_drive_cyc = -1;
    int          cap17_cyc = -1;

    // monitor observations
    int          words_seen = 0;
    int          sof_seen = 0;
    int          eol_seen = 0;
    int          done_seen = 0;
    int          first_cyc = -1;
    int          ovf_first_cyc = -1;
    logic        first_sof = 1'b0;
    logic [23:0] first_data = '0;

    typedef struct {
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        repl;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [7:0] expandRef(input logic [3:0] c, input logic repl);
        return repl ? 8'(c * 17) : 8'(c * 16);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic rst);
        logic       fstart;
        logic       fend;
        logic       active;
        logic       eol;
        @(posedge CLK);
        #1;
        if (hc == HP - 1) begin
            hc = 0;
            vc = (vc == VP - 1) ? 0 : vc + 1;
        end else begin
            hc++;
        end
        RST     = rst;
        HCNT    = 10'(hc);
        VCNT    = 10'(vc);
        START   = start;
        NFRAMES = cfg_nframes;
        REPL    = cfg_repl;
        if (cfg_fixed) begin
            VGA_R = fix_r;
            VGA_G = fix_g;
            VGA_B = fix_b;
        end else begin
            VGA_R = 4'($urandom);
            VGA_G = 4'($urandom);
            VGA_B = 4'($urandom);
        end
        case (ready_mode)
            0:       OUT_READY = 1'b0;
            1:       OUT_READY = 1'b1;
            default: OUT_READY = (exp_q.size() >= 10) ? 1'b1 : ($urandom_range(0, 3) != 0);
        endcase
        if (rst) begin
            OUT_READY = 1'b0;
            m_mode = 0;
            exp_q.delete();
        end else begin
            fstart = (hc == HB) && (vc == VB);
            fend   = (hc == HP - 1) && (vc == VP - 1);
            active = (hc >= HB) && (vc >= VB);
            eol    = (hc == HP - 1);
            if (m_mode == 1 && fstart) m_mode = 2;
            if (m_mode == 2) begin
                if (active) begin
                    exp_q.push_back({fstart, eol, expandRef(VGA_R, cfg_repl),
                                     expandRef(VGA_G, cfg_repl), expandRef(VGA_B, cfg_repl)});
                    push_idx++;
                    if (push_idx == 1 && fstart) sof_drive_cyc = cyc;
                    if (push_idx == FD + 1) cap17_cyc = cyc;
                end
                if (fend) begin
                    m_frames_left--;
                    if (m_frames_left == 0) m_mode = 3;
                end
            end
            if (start && m_mode == 0) begin
                m_mode = 1;
                m_frames_left = (cfg_nframes == 0) ? 1 : int'(cfg_nframes);
            end
        end
    endtask

    task automatic newRun(input logic [7:0] nframes, input logic repl, input int rmode);
        cfg_nframes   = nframes;
        cfg_repl      = repl;
        ready_mode    = rmode;
        cfg_fixed     = 1'b0;
        m_mode        = 0;
        push_idx      = 0;
        sof_drive_cyc = -1;
        cap17_cyc     = -1;
        words_seen    = 0;
        sof_seen      = 0;
        eol_seen      = 0;
        done_seen     = 0;
        first_cyc     = -1;
        ovf_first_cyc = -1;
        first_sof     = 1'b0;
        first_data    = '0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done_seen == 0 && n < budget) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        if (done_seen == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done_timeout: no DONE after %0d cycles, required one pulse", budget);
        end
        repeat (3) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic finishRun(input string tag, input int exp_words, input int exp_sof,
                             input int exp_eol, input logic exp_ovf);
        @(negedge CLK);
        checkOutput({tag, "_words"}, words_seen, exp_words);
        checkOutput({tag, "_sof"}, sof_seen, exp_sof);
        checkOutput({tag, "_eol"}, eol_seen, exp_eol);
        checkOutput({tag, "_done"}, done_seen, 1);
        checkOutput({tag, "_leftover"}, exp_q.size(), 0);
        checkOutput({tag, "_busy"}, BUSY, 0);
        checkOutput({tag, "_ovf"}, OVF, exp_ovf);
        checkOutput({tag, "_first_sof"}, first_sof, 1);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (DONE) done_seen++;
                if (OVF && ovf_first_cyc < 0) ovf_first_cyc = cyc;
                if (OUT_VALID && OUT_READY) begin
                    words_seen++;
                    if (words_seen == 1) begin
                        first_cyc  = cyc;
                        first_sof  = OUT_SOF;
                        first_data = OUT_DATA;
                    end
                    sof_seen += int'(OUT_SOF);
                    eol_seen += int'(OUT_EOL);
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL word: got %0h with no word expected", {OUT_SOF, OUT_EOL, OUT_DATA});
                    end else begin
                        checkOutput("word", {6'b0, OUT_SOF, OUT_EOL, OUT_DATA}, {6'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        logic [25:0] head;

        vecs[0] = '{4'hA, 4'h5, 4'hF, 1'b1, 24'hAA55FF};
        vecs[1] = '{4'hA, 4'h5, 4'hF, 1'b0, 24'hA050F0};
        vecs[2] = '{4'h0, 4'hF, 4'h1, 1'b1, 24'h00FF11};
        vecs[3] = '{4'hF, 4'hF, 4'hF, 1'b0, 24'hF0F0F0};
        vecs[4] = '{4'h3, 4'hC, 4'h7, 1'b1, 24'h33CC77};
        vecs[5] = '{4'h1, 4'h2, 4'h8, 1'b0, 24'h102080};

        repeat (3) applyStimulus(1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("rst_valid", OUT_VALID, 0);
        checkOutput("rst_data", OUT_DATA, 0);
        checkOutput("rst_sof", OUT_SOF, 0);
        checkOutput("rst_eol", OUT_EOL, 0);
        checkOutput("rst_busy", BUSY, 0);
        checkOutput("rst_done", DONE, 0);
        checkOutput("rst_ovf", OVF, 0);
        applyStimulus(1'b0, 1'b0);

        // colour expansion vectors, one single-frame capture each
        for (int i = 0; i < 6; i++) begin
            newRun(8'd1, vecs[i].repl, 2);
            cfg_fixed = 1'b1;
            fix_r = vecs[i].r;
            fix_g = vecs[i].g;
            fix_b = vecs[i].b;
            repeat ($urandom_range(0, 60)) applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0);
            waitDone(3000);
            finishRun($sformatf("tbl%0d", i), FRAME_WORDS, 1, FRAME_LINES, 1'b0);
            checkOutput($sformatf("tbl%0d_data", i), first_data, vecs[i].exp);
        end

        // three frames, random colours and back-pressure
        newRun(8'd3, 1'($urandom_range(0, 1)), 2);
        repeat ($urandom_range(0, 60)) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitDone(5000);
        finishRun("nf3", 3 * FRAME_WORDS, 3, 3 * FRAME_LINES, 1'b0);

        // NFRAMES=0 counts as one frame; a second START mid-capture is ignored
        newRun(8'd0, 1'b1, 2);
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (push_idx < 20 && n < 2000) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        applyStimulus(1'b1, 1'b0);
        waitDone(3000);
        finishRun("nf0", FRAME_WORDS, 1, FRAME_LINES, 1'b0);

        // START inside active video waits for the next frame; latency of two cycles
        newRun(8'd1, 1'b0, 1);
        n = 0;
        while (!(hc == HB + 5 && vc == VB + 2) && n < 500) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        applyStimulus(1'b1, 1'b0);
        waitDone(3000);
        finishRun("act", FRAME_WORDS, 1, FRAME_LINES, 1'b0);
        checkOutput("latency", first_cyc - sof_drive_cyc, 2);

        // no reader for a whole frame: only the first FD words survive
        newRun(8'd1, 1'b0, 0);
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (m_mode != 3 && n < 2000) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        repeat (3) applyStimulus(1'b0, 1'b0);
        @(negedge CLK);
        head = exp_q[0];
        checkOutput("ovf_set", OVF, 1);
        checkOutput("ovf_busy", BUSY, 1);
        checkOutput("ovf_valid", OUT_VALID, 1);
        checkOutput("ovf_hold_data", OUT_DATA, head[23:0]);
        checkOutput("ovf_hold_sof", OUT_SOF, head[25]);
        checkOutput("ovf_timing", ovf_first_cyc, cap17_cyc + 2);
        while (exp_q.size() > FD) void'(exp_q.pop_back());
        ready_mode = 1;
        waitDone(3000);
        finishRun("ovf", FD, 1, 1, 1'b1);

        // new START clears OVF; reset mid-line then immediate restart
        newRun(8'd1, 1'b0, 2);
        applyStimulus(1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("ovf_cleared", OVF, 0);
        n = 0;
        while (push_idx < 30 && n < 2000) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("rst_mid_no_done", done_seen, 0);
        newRun(8'd1, 1'b0, 2);
        applyStimulus(1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("rst_mid_valid", OUT_VALID, 0);
        checkOutput("rst_mid_busy", BUSY, 0);
        waitDone(3000);
        finishRun("rst", FRAME_WORDS, 1, FRAME_LINES, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
